mem_arbiter: RTL and testbench

Arbitrates a single-port, fixed-latency SRAM between the IF-stage instruction fetch port and the MEM-stage data port of the 5-stage pipeline. Sequences each access through a small FSM and a wait counter, returns read data with a one-cycle ready pulse, and drives the pipeline-wide `freeze` while a data access is outstanding. Sits between `if_stage`/`mem_stage` and the external SRAM controller pins.

---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Purpose  : Bundles the fetch port, data port and SRAM pins that connect
//            to mem_arbiter.
// Revision : 1.0 - initial release
// Modports :
//   slave  - the arbiter. It receives requests and sram_rdata, and drives
//            ready/rdata, freeze and the SRAM strobes.
//   master - the pipeline/SRAM side. It is the mirror of slave.
// ============================================================================
interface mem_arbiter_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int SRAM_ADDR_WIDTH = 30
);
  logic                       if_req;
  logic [ADDR_WIDTH-1:0]      if_addr;
  logic [DATA_WIDTH-1:0]      if_rdata;
  logic                       if_ready;
  logic                       mem_rd_req;
  logic                       mem_wr_req;
  logic [ADDR_WIDTH-1:0]      mem_addr;
  logic [DATA_WIDTH-1:0]      mem_wdata;
  logic [DATA_WIDTH-1:0]      mem_rdata;
  logic                       mem_ready;
  logic                       freeze;
  logic                       sram_en;
  logic                       sram_we;
  logic [SRAM_ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0]      sram_wdata;
  logic [DATA_WIDTH-1:0]      sram_rdata;

  modport slave (
    input  if_req, if_addr, mem_rd_req, mem_wr_req, mem_addr, mem_wdata,
           sram_rdata,
    output if_rdata, if_ready, mem_rdata, mem_ready, freeze,
           sram_en, sram_we, sram_addr, sram_wdata
  );

  modport master (
    output if_req, if_addr, mem_rd_req, mem_wr_req, mem_addr, mem_wdata,
           sram_rdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready, freeze,
           sram_en, sram_we, sram_addr, sram_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one fixed-latency single-port SRAM between the IF fetch
//            port and the MEM data port. Each access runs IDLE -> ACCESS
//            (WAIT_CYCLES cycles) -> DONE. Read data is returned together
//            with a one-cycle ready pulse. The module stalls the pipeline
//            while a data access is outstanding.
// Revision : 1.0 - initial release
// Ports    :
//   clk - system clock, rising edge
//   rst - synchronous reset, active-low
//   bus - mem_arbiter_if.slave, which carries:
//         if_req/if_addr/if_rdata/if_ready                  fetch port
//         mem_rd_req/mem_wr_req/mem_addr/mem_wdata/
//         mem_rdata/mem_ready                               data port
//         freeze                                            pipeline stall
//         sram_en/sram_we/sram_addr/sram_wdata/sram_rdata   SRAM pins
// Config   : MEM_ARB_RR_EN - when defined, a tie in IDLE goes to the port
//            that was not granted last time. Otherwise MEM always wins.
// ============================================================================
module mem_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int SRAM_ADDR_WIDTH = 30,
  parameter int WAIT_CYCLES     = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam logic [3:0] LAST_CNT  = 4'(WAIT_CYCLES - 1);
  localparam logic       GRANT_IF  = 1'b0;
  localparam logic       GRANT_MEM = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                     state, state_next;
  logic                       grant, grant_next;
  logic                       is_write, is_write_next;
  logic [3:0]                 wait_cnt, wait_cnt_next;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_next;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_next;
  logic [DATA_WIDTH-1:0]      if_rdata_q, if_rdata_next;
  logic [DATA_WIDTH-1:0]      mem_rdata_q, mem_rdata_next;
  logic                       mem_req;
  logic                       pick_mem;
  logic                       unused_addr_bits;

  // The SRAM is word addressed, so the byte offsets are not used.
  assign unused_addr_bits = ^{bus.if_addr[1:0], bus.mem_addr[1:0]};

  assign mem_req = bus.mem_rd_req | bus.mem_wr_req;

`ifdef MEM_ARB_RR_EN
  logic last_grant, last_grant_next;
  // On a tie, MEM wins only when IF was the port granted last time.
  assign pick_mem = mem_req & (~bus.if_req | (last_grant == GRANT_IF));
`else
  assign pick_mem = mem_req;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      grant       <= GRANT_IF;
      is_write    <= 1'b0;
      wait_cnt    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_grant  <= GRANT_IF;
`endif
    end else begin
      state       <= state_next;
      grant       <= grant_next;
      is_write    <= is_write_next;
      wait_cnt    <= wait_cnt_next;
      addr_q      <= addr_next;
      wdata_q     <= wdata_next;
      if_rdata_q  <= if_rdata_next;
      mem_rdata_q <= mem_rdata_next;
`ifdef MEM_ARB_RR_EN
      last_grant  <= last_grant_next;
`endif
    end
  end

  always_comb begin
    state_next      = state;
    grant_next      = grant;
    is_write_next   = is_write;
    wait_cnt_next   = wait_cnt;
    addr_next       = addr_q;
    wdata_next      = wdata_q;
    if_rdata_next   = if_rdata_q;
    mem_rdata_next  = mem_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_grant_next = last_grant;
`endif
    case (state)
      IDLE: begin
        if (mem_req | bus.if_req) begin
          grant_next      = pick_mem;
          // When read and write are requested together, the access is a write.
          is_write_next   = pick_mem & bus.mem_wr_req;
          addr_next       = pick_mem ? bus.mem_addr[ADDR_WIDTH-1:2]
                                     : bus.if_addr[ADDR_WIDTH-1:2];
          wdata_next      = pick_mem ? bus.mem_wdata : '0;
          wait_cnt_next   = '0;
          state_next      = ACCESS;
`ifdef MEM_ARB_RR_EN
          last_grant_next = pick_mem;
`endif
        end
      end
      ACCESS: begin
        if (wait_cnt == LAST_CNT) begin
          if (grant == GRANT_MEM) mem_rdata_next = bus.sram_rdata;
          else                    if_rdata_next  = bus.sram_rdata;
          state_next = DONE;
        end else begin
          wait_cnt_next = wait_cnt + 4'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.sram_en    = (state == ACCESS);
  assign bus.sram_we    = (state == ACCESS) & is_write;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.mem_rdata  = mem_rdata_q;
  assign bus.if_ready   = (state == DONE) & (grant == GRANT_IF);
  assign bus.mem_ready  = (state == DONE) & (grant == GRANT_MEM);

  // Freeze is forced low while rst is asserted, so the pipeline is not
  // stalled against an arbiter that is being cleared.
  assign bus.freeze = rst & ((mem_req & ~bus.mem_ready) |
                             (bus.if_req & ~bus.if_ready & (grant == GRANT_MEM)));

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. The bench uses directed
//            scenarios and random traffic. A transaction-level timing model
//            computes the expected behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SRAM_ADDR_WIDTH(30)) bus ();
  mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SRAM_ADDR_WIDTH(30)) bus1 ();

  mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SRAM_ADDR_WIDTH(30),
                .WAIT_CYCLES(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SRAM_ADDR_WIDTH(30),
                .WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // stimulus
  logic        rst_v, if_req_v, mem_rd_v, mem_wr_v, r1_req;
  logic [31:0] if_addr_v, mem_addr_v, mem_wdata_v, rdata_v;

  // Transaction model: an access granted in cycle s occupies the SRAM in
  // cycles s+1..s+W and reports ready in cycle s+W+1.
  bit          busy, port, wr, gport, model_ok;
  int          s, cyc;
  logic [29:0] m_addr;
  logic [31:0] m_wdata, m_if_rd, m_mem_rd;
  bit          if_done_now, mem_done_now;
  int          if_done_cyc, mem_done_cyc, mem_ready_seen, t0;
  int          r1_q[$];
  int          checks, errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    bit acc, done, mreq, pick;
    @(negedge clk);
    rst             = rst_v;
    bus.if_req      = if_req_v;
    bus.if_addr     = if_addr_v;
    bus.mem_rd_req  = mem_rd_v;
    bus.mem_wr_req  = mem_wr_v;
    bus.mem_addr    = mem_addr_v;
    bus.mem_wdata   = mem_wdata_v;
    bus.sram_rdata  = rdata_v;
    bus1.if_req     = r1_req;
    #1;
    acc  = busy && (cyc >= s + 1) && (cyc <= s + W);
    done = busy && (cyc == s + W + 1);
    mreq = mem_rd_v || mem_wr_v;
    if_done_now  = done && !port;
    mem_done_now = done && port;
    if (model_ok) begin
      check("sram_en",   32'(bus.sram_en),   32'(acc));
      check("sram_we",   32'(bus.sram_we),   32'(acc && wr));
      if (acc) begin
        check("sram_addr", 32'(bus.sram_addr), 32'(m_addr));
        if (wr) check("sram_wdata", bus.sram_wdata, m_wdata);
      end
      check("if_ready",  32'(bus.if_ready),  32'(if_done_now));
      check("mem_ready", 32'(bus.mem_ready), 32'(mem_done_now));
      check("if_rdata",  bus.if_rdata,  m_if_rd);
      check("mem_rdata", bus.mem_rdata, m_mem_rd);
      check("freeze", 32'(bus.freeze),
            32'(rst_v && ((mreq && !mem_done_now) || (if_req_v && !if_done_now && gport))));
    end
    if (bus.mem_ready) mem_ready_seen++;
    if (bus1.if_ready) r1_q.push_back(cyc);
    if (if_done_now)  if_done_cyc  = cyc;
    if (mem_done_now) mem_done_cyc = cyc;
    // Model update for the upcoming edge.
    if (busy && cyc == s + W) begin
      if (port) m_mem_rd = rdata_v;
      else      m_if_rd  = rdata_v;
    end
    if (done) busy = 1'b0;
    else if (!busy && (mreq || if_req_v)) begin
`ifdef MEM_ARB_RR_EN
      pick = mreq && (!if_req_v || !gport);
`else
      pick = mreq;
`endif
      busy    = 1'b1;
      s       = cyc;
      port    = pick;
      wr      = pick && mem_wr_v;
      m_addr  = pick ? mem_addr_v[31:2] : if_addr_v[31:2];
      m_wdata = mem_wdata_v;
      gport   = pick;
    end
    if (!rst_v) begin
      busy = 1'b0; gport = 1'b0; m_if_rd = '0; m_mem_rd = '0; model_ok = 1'b1;
    end
    cyc++;
  endtask

  // Steps until both requesters are satisfied; each drops its request on its ready.
  task automatic serve(input int maxc);
    int n = 0;
    while ((if_req_v || mem_rd_v || mem_wr_v || busy) && n < maxc) begin
      step();
      if (if_done_now)  if_req_v = 1'b0;
      if (mem_done_now) begin mem_rd_v = 1'b0; mem_wr_v = 1'b0; end
      n++;
    end
    check("serve_drained", 32'(if_req_v || mem_rd_v || mem_wr_v || busy), 32'd0);
  endtask

  task automatic set_mem(input int k);
    mem_rd_v    = (k == 1) || (k == 3);
    mem_wr_v    = (k == 2) || (k == 3);
    mem_addr_v  = $urandom;
    mem_wdata_v = $urandom;
  endtask

  task automatic random_cycle();
    if (if_req_v) begin
      if (if_done_now) begin if_req_v = 1'($urandom_range(0, 1)); if_addr_v = $urandom; end
    end else if ($urandom_range(0, 2) == 0) begin
      if_req_v = 1'b1; if_addr_v = $urandom;
    end
    if (mem_rd_v || mem_wr_v) begin
      if (mem_done_now) set_mem(int'($urandom_range(0, 3)));
    end else if ($urandom_range(0, 2) == 0) begin
      set_mem(int'($urandom_range(1, 3)));
    end
    rdata_v = $urandom;
    rst_v   = ($urandom_range(0, 149) != 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; model_ok = 1'b0; busy = 1'b0; gport = 1'b0;
    s = 0; port = 1'b0; wr = 1'b0; m_addr = '0; m_wdata = '0; m_if_rd = '0; m_mem_rd = '0;
    if_done_cyc = 0; mem_done_cyc = 0; mem_ready_seen = 0;
    bus1.if_addr = 32'h0; bus1.mem_rd_req = 1'b0; bus1.mem_wr_req = 1'b0;
    bus1.mem_addr = 32'h0; bus1.mem_wdata = 32'h0; bus1.sram_rdata = 32'h1234_5678;
    r1_req = 1'b0;

    // Reset held for two cycles with requests high.
    rst_v = 1'b0; if_req_v = 1'b1; if_addr_v = 32'h40;
    mem_rd_v = 1'b1; mem_wr_v = 1'b1; mem_addr_v = 32'h80; mem_wdata_v = 32'h5;
    rdata_v = 32'h0;
    step(); step();
    rst_v = 1'b1; if_req_v = 1'b0; mem_rd_v = 1'b0; mem_wr_v = 1'b0;
    step();

    // IF read
    if_req_v = 1'b1; if_addr_v = 32'h0000_0010; rdata_v = 32'hE3A0_1005;
    t0 = cyc; serve(20);
    check("if_latency", 32'(if_done_cyc - t0), 32'(W + 1));
    check("if_word", bus.if_rdata, 32'hE3A0_1005);

    // MEM write
    mem_wr_v = 1'b1; mem_addr_v = 32'h100; mem_wdata_v = 32'hDEAD_BEEF;
    t0 = cyc; serve(20);
    check("wr_latency", 32'(mem_done_cyc - t0), 32'(W + 1));

    // IF and MEM requests raised in the same cycle
    if_req_v = 1'b1; if_addr_v = 32'h20; mem_rd_v = 1'b1; mem_addr_v = 32'h200;
    rdata_v = 32'hA5A5_0001;
    t0 = cyc; serve(40);
`ifdef MEM_ARB_RR_EN
    check("tie_if_latency",  32'(if_done_cyc - t0),  32'(W + 1));
    check("tie_mem_latency", 32'(mem_done_cyc - t0), 32'(2 * W + 3));
`else
    check("tie_mem_latency", 32'(mem_done_cyc - t0), 32'(W + 1));
    check("tie_if_latency",  32'(if_done_cyc - t0),  32'(2 * W + 3));
`endif

    // Reset during the second ACCESS cycle of a write
    mem_wr_v = 1'b1; mem_addr_v = 32'h300; mem_wdata_v = 32'h0BAD_F00D;
    step(); step();
    rst_v = 1'b0; mem_wr_v = 1'b0; mem_ready_seen = 0;
    step();
    rst_v = 1'b1;
    step();
    check("abort_en", 32'(bus.sram_en), 32'd0);
    if_req_v = 1'b1; if_addr_v = 32'h44; rdata_v = 32'h7777_0044;
    t0 = cyc; serve(20);
    check("post_abort_latency", 32'(if_done_cyc - t0), 32'(W + 1));
    check("abort_no_ready", 32'(mem_ready_seen), 32'd0);

    // Random traffic with occasional resets
    repeat (1500) begin
      random_cycle();
      step();
    end
    rst_v = 1'b1;
    serve(60);

    // WAIT_CYCLES=1 with the fetch request held high
    r1_q.delete();
    r1_req = 1'b1;
    t0 = cyc;
    repeat (12) step();
    r1_req = 1'b0;
    check("w1_pulses", 32'(r1_q.size()), 32'd4);
    if (r1_q.size() > 0) check("w1_first", 32'(r1_q[0] - t0), 32'd2);
    for (int i = 1; i < r1_q.size(); i++)
      check("w1_gap", 32'(r1_q[i] - r1_q[i-1]), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
